param_sys_array: RTL and testbench
==================================

# param_sys_array

Parametrised output-stationary systolic array for the attention datapath. It computes C = A·B for an ROWS×DEPTH operand A and a DEPTH×COLS operand B on a ROWS×COLS grid of MAC processing elements. Operands are skew-fed internally. The block returns every product element, a scalar importance score (sum of all elements) and a one-cycle done pulse. It generalises the fixed 2×4·4×2 integer array to arbitrary dimensions and adds a fixed-point mode.

## Interface
- WIDTH, 8: operand element width, signed two's complement.
- ROWS, 2: rows of A and C.
- COLS, 2: columns of B and C.
- DEPTH, 4: inner dimension K.
- FRAC, 4: fractional bits used in fixed-point mode; must be < WIDTH.

- clk  in  1  single clock, rising edge.
- _reset  in  1  reset, synchronous, active-low.
- enable  in  1  start request; accepted only when ready=1.
- intMul  in  1  mode, sampled at accept: 1 = integer, 0 = fixed-point Q(WIDTH-FRAC).FRAC.
- a_flat  in  ROWS*DEPTH*WIDTH  A elements; element (i,k) at bit offset (i*DEPTH+k)*WIDTH.
- b_flat  in  DEPTH*COLS*WIDTH  B elements; element (k,j) at bit offset (k*COLS+j)*WIDTH.
- ready  out  1  high in IDLE.
- result_flat  out  ROWS*COLS*2*WIDTH  C elements; element (i,j) at bit offset (i*COLS+j)*2*WIDTH.
- importance  out  2*WIDTH  sum of all C elements.
- done  out  1  one-cycle pulse when result_flat and importance update.

## Operation
- States are IDLE, RUN and DONE.
- IDLE, enable=1: capture a_flat, b_flat and intMul into internal registers, clear all accumulators, clear cnt, go to RUN. enable=0 keeps the block in IDLE.
- RUN: cnt increments every cycle. PE(i,j) MACs a(i,k)·b(k,j) when cnt = k+i+j. Skew is realised by A propagating right and B propagating down through PE pass-through registers. Leave RUN after cnt = T-1, where T = DEPTH+ROWS+COLS-2.
- DONE: register all accumulators into result_flat, register their sum into importance, assert done, go to IDLE.
- enable is ignored in RUN and DONE. Deasserting enable mid-run does not abort the operation.
- Arithmetic:
  - Product is the full 2*WIDTH signed value.
  - If intMul=0, the product is arithmetic-shifted right by FRAC before accumulation.
  - Accumulators and the importance sum are 2*WIDTH and wrap in two's complement, with no saturation.
- result_flat and importance hold their values until the next DONE.
- _reset=0 at any edge: state IDLE, accumulators 0, result_flat 0, importance 0, done 0, ready 1. A run interrupted by reset produces no done pulse.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..T. DONE occupies cycle T+1, with done=1 and outputs valid from that cycle on.
- With defaults, T=6 and done is seen in cycle 7.
- ready is 0 in cycles 1..T+1 and returns to 1 in cycle T+2.
- Minimum start-to-start interval is T+2 cycles.
- Output reset values: ready=1, done=0, result_flat=0, importance=0.

## Configuration
- IMPORTANCE_EN defined: importance adder tree and register are built as described.
- IMPORTANCE_EN undefined: no adder tree; importance is tied to 0. All other behaviour and timing are unchanged.

## Structure
- Package sa_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam function sa_latency(ROWS,COLS,DEPTH) returning T;
  - the flat-vector index helper functions.
- Sub-module sa_pe has one accumulator, one A pass-through register and one B pass-through register. Its inputs are mac_en, clr, intMul and FRAC. ROWS×COLS instances are generated.

## Test plan
- Defaults, intMul=1; A row0=[1,0,1,0], row1=0; B all 1 -> C(0,0)=C(0,1)=2, row1=0, importance=4, done in cycle 7.
- Immediately after that test, reset pulse, then same B with A row1=[1,1,1,1] -> C row0=2,2; row1=4,4; importance=12.
- intMul=1, all A and B = -128 (8'h80) -> each product 16384, 4×16384 wraps -> all C=0, importance=0.
- intMul=0, FRAC=4; A all 16 (1.0), B all 32 (2.0) -> each product 512>>4=32 -> C=128 (8.0), importance=512.
- Start, then _reset=0 in cycle 3 -> next cycle ready=1 and outputs 0; no done pulse at cycle 7.
- enable held high for 20 cycles -> accepts at cycles 0 and 8; done at cycles 7 and 15; inputs changed during RUN do not affect the result.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and index helpers for the param_sys_array output-stationary systolic array.
package sa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_e;

  // Cycles spent in RUN: the last PE sees its last operand pair at cnt = T-1.
  function automatic int sa_latency(input int rows, input int cols, input int depth);
    return depth + rows + cols - 2;
  endfunction

  function automatic int a_off(input int i, input int k, input int depth, input int width);
    return (i * depth + k) * width;
  endfunction

  function automatic int b_off(input int k, input int j, input int cols, input int width);
    return (k * cols + j) * width;
  endfunction

  function automatic int c_off(input int i, input int j, input int cols, input int width);
    return (i * cols + j) * 2 * width;
  endfunction

endpackage

// File: rtl/param_sys_array_if.sv
// Start/operand/result bundle of param_sys_array; slave is the array side, master the requester.
interface param_sys_array_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int DEPTH = 4
);
  logic                          enable;
  logic                          intMul;
  logic [ROWS*DEPTH*WIDTH-1:0]   a_flat;
  logic [DEPTH*COLS*WIDTH-1:0]   b_flat;
  logic                          ready;
  logic [ROWS*COLS*2*WIDTH-1:0]  result_flat;
  logic [2*WIDTH-1:0]            importance;
  logic                          done;

  modport slave  (input  enable, intMul, a_flat, b_flat,
                  output ready, result_flat, importance, done);
  modport master (output enable, intMul, a_flat, b_flat,
                  input  ready, result_flat, importance, done);
endinterface

// File: rtl/sa_pe.sv
// One MAC cell: wrapping accumulator plus A (rightward) and B (downward) pass-through registers.
module sa_pe #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic                      mac_en,
  input  logic                      clr,
  input  logic                      intMul,
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  output logic signed [WIDTH-1:0]   a_o,
  output logic signed [WIDTH-1:0]   b_o,
  output logic signed [2*WIDTH-1:0] acc_nxt_o
);
  localparam int AW = 2 * WIDTH;

  function automatic logic signed [AW-1:0] scale_prod(input logic signed [AW-1:0] p,
                                                      input logic int_mode);
    return int_mode ? p : (p >>> FRAC);
  endfunction

  logic signed [AW-1:0]    acc_q, acc_d, prod;
  logic signed [WIDTH-1:0] a_q, b_q;

  always_comb begin
    prod  = AW'(a_i) * AW'(b_i);
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (mac_en)
      acc_d = acc_q + scale_prod(prod, intMul);
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (clr) begin
        a_q <= '0;
        b_q <= '0;
      end else if (mac_en) begin
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign acc_nxt_o = acc_d;
endmodule

// File: rtl/param_sys_array.sv
// ROWSxCOLS output-stationary systolic array computing C = A*B with importance sum and done pulse.
// Build with IMPORTANCE_EN defined to include the importance adder tree; otherwise importance is 0.
module param_sys_array
  import sa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int DEPTH = 4,
  parameter int FRAC  = 4
) (
  input logic              clk,
  input logic              _reset,
  param_sys_array_if.slave bus
);
  localparam int T  = sa_latency(ROWS, COLS, DEPTH);
  localparam int CW = $clog2(T + 1);
  localparam int AW = 2 * WIDTH;

  sa_state_e                    state_q;
  logic [CW-1:0]                cnt_q;
  logic                         int_q, done_q, ready_q;
  logic [ROWS*COLS*AW-1:0]      res_q;
  logic signed [WIDTH-1:0]      a_q [ROWS][DEPTH];
  logic signed [WIDTH-1:0]      b_q [DEPTH][COLS];
  logic signed [WIDTH-1:0]      a_edge [ROWS];
  logic signed [WIDTH-1:0]      b_edge [COLS];
  logic signed [WIDTH-1:0]      a_h [ROWS][COLS+1];
  logic signed [WIDTH-1:0]      b_v [ROWS+1][COLS];
  logic signed [AW-1:0]         acc_nxt [ROWS][COLS];
  logic                         start, mac_en, last;

  assign start  = (state_q == IDLE) && bus.enable;
  assign mac_en = (state_q == RUN);
  assign last   = mac_en && (cnt_q == CW'(T - 1));

  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < ROWS; i++)
        for (int k = 0; k < DEPTH; k++)
          a_q[i][k] <= bus.a_flat[a_off(i, k, DEPTH, WIDTH) +: WIDTH];
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < COLS; j++)
          b_q[k][j] <= bus.b_flat[b_off(k, j, COLS, WIDTH) +: WIDTH];
    end
  end

  // Edge skew: row i sees a(i,k) at cnt=i+k, column j sees b(k,j) at cnt=k+j, zero otherwise.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_edge[i] = '0;
      for (int k = 0; k < DEPTH; k++)
        if (int'(cnt_q) == i + k) a_edge[i] = a_q[i][k];
    end
    for (int j = 0; j < COLS; j++) begin
      b_edge[j] = '0;
      for (int k = 0; k < DEPTH; k++)
        if (int'(cnt_q) == k + j) b_edge[j] = b_q[k][j];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_aedge
    assign a_h[gi][0] = a_edge[gi];
  end
  for (genvar gj = 0; gj < COLS; gj++) begin : g_bedge
    assign b_v[0][gj] = b_edge[gj];
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      sa_pe #(.WIDTH(WIDTH), .FRAC(FRAC)) u_pe (
        .clk       (clk),
        .rst_ni    (_reset),
        .mac_en    (mac_en),
        .clr       (start),
        .intMul    (int_q),
        .a_i       (a_h[gi][gj]),
        .b_i       (b_v[gi][gj]),
        .a_o       (a_h[gi][gj+1]),
        .b_o       (b_v[gi+1][gj]),
        .acc_nxt_o (acc_nxt[gi][gj])
      );
    end
  end

  // Results latch from the accumulators' next value so they are valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.enable) begin
          state_q <= RUN;
          cnt_q   <= '0;
          int_q   <= bus.intMul;
          ready_q <= 1'b0;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            for (int i = 0; i < ROWS; i++)
              for (int j = 0; j < COLS; j++)
                res_q[c_off(i, j, COLS, WIDTH) +: AW] <= acc_nxt[i][j];
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IMPORTANCE_EN
  logic signed [AW-1:0] imp_sum, imp_q;

  always_comb begin
    imp_sum = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        imp_sum = imp_sum + acc_nxt[i][j];
  end

  always_ff @(posedge clk) begin
    if (!_reset)
      imp_q <= '0;
    else if (last)
      imp_q <= imp_sum;
  end

  assign bus.importance = imp_q;
`else
  assign bus.importance = '0;
`endif

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.result_flat = res_q;
endmodule

// File: tb/tb_param_sys_array.sv
// Directed self-checking bench for param_sys_array at default dimensions (2x4 * 4x2, WIDTH 8).
module tb_param_sys_array;
  localparam int W = 8;
  localparam int R = 2;
  localparam int C = 2;
  localparam int D = 4;
`ifdef IMPORTANCE_EN
  localparam bit IMP_ON = 1'b1;
`else
  localparam bit IMP_ON = 1'b0;
`endif

  // A/B operands (lowest byte = element (0,0)) and packed C (lowest 16 bits = C(0,0)).
  localparam logic [63:0] A1   = 64'h0000_0000_0001_0001;
  localparam logic [63:0] A2   = 64'h0101_0101_0001_0001;
  localparam logic [63:0] ONES = 64'h0101_0101_0101_0101;
  localparam logic [63:0] M128 = 64'h8080_8080_8080_8080;
  localparam logic [63:0] Q1P0 = 64'h1010_1010_1010_1010;
  localparam logic [63:0] Q2P0 = 64'h2020_2020_2020_2020;
  localparam logic [63:0] JUNK = 64'h7F7F_7F7F_7F7F_7F7F;
  localparam logic [63:0] R1   = 64'h0000_0000_0002_0002;
  localparam logic [63:0] R2   = 64'h0004_0004_0002_0002;
  localparam logic [63:0] R4   = 64'h0080_0080_0080_0080;

  logic clk = 1'b0;
  logic _reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  param_sys_array_if #(.WIDTH(W), .ROWS(R), .COLS(C), .DEPTH(D)) bus ();

  param_sys_array #(.WIDTH(W), .ROWS(R), .COLS(C), .DEPTH(D), .FRAC(4)) dut (
    .clk    (clk),
    ._reset (_reset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] imp_exp(input logic [63:0] v);
    return IMP_ON ? v : 64'd0;
  endfunction

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (bus.ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk({tag, "_ready_wait"}, 64'(bus.ready), 64'd1);
  endtask

  // Leaves the caller at the negedge of cycle 1 (first RUN cycle).
  task automatic start_run(input string tag, input logic im, input logic [63:0] a, input logic [63:0] b);
    wait_ready(tag);
    bus.intMul = im;
    bus.a_flat = a;
    bus.b_flat = b;
    bus.enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic im, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] res, input logic [63:0] imp);
    int cyc = 1;
    start_run(tag, im, a, b);
    chk({tag, "_ready_low"}, 64'(bus.ready), 64'd0);
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, 64'(cyc), 64'd7);
    chk({tag, "_result"}, bus.result_flat, res);
    chk({tag, "_importance"}, 64'(bus.importance), imp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
  endtask

  initial begin
    int dcount;
    bus.enable = 1'b0;
    bus.intMul = 1'b1;
    bus.a_flat = '0;
    bus.b_flat = '0;
    _reset     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", bus.result_flat, 64'd0);
    chk("rst_imp", 64'(bus.importance), 64'd0);
    _reset = 1'b1;
    @(negedge clk);

    run_check("t1_int", 1'b1, A1, ONES, R1, imp_exp(64'd4));

    _reset = 1'b0;
    @(negedge clk);
    chk("t2_rst_result", bus.result_flat, 64'd0);
    chk("t2_rst_ready", 64'(bus.ready), 64'd1);
    _reset = 1'b1;
    @(negedge clk);
    run_check("t2_int", 1'b1, A2, ONES, R2, imp_exp(64'd12));

    run_check("t3_wrap", 1'b1, M128, M128, 64'd0, 64'd0);

    run_check("t4_fix", 1'b0, Q1P0, Q2P0, R4, imp_exp(64'd512));

    start_run("t5", 1'b1, A2, ONES);
    @(negedge clk);
    _reset = 1'b0;
    @(negedge clk);
    chk("t5_ready", 64'(bus.ready), 64'd1);
    chk("t5_done", 64'(bus.done), 64'd0);
    chk("t5_result", bus.result_flat, 64'd0);
    chk("t5_imp", 64'(bus.importance), 64'd0);
    _reset = 1'b1;
    dcount = 0;
    for (int c = 5; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    chk("t5_no_done", 64'(dcount), 64'd0);

    wait_ready("t6");
    bus.intMul = 1'b1;
    bus.a_flat = A1;
    bus.b_flat = ONES;
    bus.enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dcount = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done === 1'b1) dcount++;
      case (c)
        2, 10: begin
          bus.a_flat = JUNK;
          bus.b_flat = JUNK;
        end
        7: begin
          chk("t6_done1", 64'(bus.done), 64'd1);
          chk("t6_result1", bus.result_flat, R1);
          chk("t6_imp1", 64'(bus.importance), imp_exp(64'd4));
          bus.a_flat = A2;
          bus.b_flat = ONES;
        end
        8: chk("t6_ready8", 64'(bus.ready), 64'd1);
        9: chk("t6_ready9", 64'(bus.ready), 64'd0);
        15: begin
          chk("t6_done2", 64'(bus.done), 64'd1);
          chk("t6_result2", bus.result_flat, R2);
          chk("t6_imp2", 64'(bus.importance), imp_exp(64'd12));
        end
        default: ;
      endcase
      @(negedge clk);
    end
    bus.enable = 1'b0;
    chk("t6_pulses", 64'(dcount), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
